// File: rtl/hcm_rmw_if.sv
// Request/lookup/readout bundle for the hit-count memory.
// master = SSID decoder / readout side, slave = hcm_rmw_pipe.
interface hcm_rmw_if #(
   parameter int ROWBITS  = 10,
   parameter int HITNBITS = 3,
   parameter int ADDRBITS = 8
);
   localparam int W = ADDRBITS + HITNBITS;

   logic                wr_valid;
   logic [ROWBITS-1:0]  wr_row;
   logic                wr_new;
   logic                wr_ready;
   logic                rd_valid;
   logic [ROWBITS-1:0]  rd_row;
   logic                rd_ready;
   logic                clear_start;
   logic                out_valid;
   logic [ROWBITS-1:0]  out_row;
   logic [W-1:0]        out_data;
   logic [HITNBITS-1:0] out_nhits;
   logic                busy;
   logic                alloc_overflow;

   modport master (
      output wr_valid, wr_row, wr_new, rd_valid, rd_row, clear_start,
      input  wr_ready, rd_ready, out_valid, out_row, out_data, out_nhits, busy, alloc_overflow
   );

   modport slave (
      input  wr_valid, wr_row, wr_new, rd_valid, rd_row, clear_start,
      output wr_ready, rd_ready, out_valid, out_row, out_data, out_nhits, busy, alloc_overflow
   );
endinterface

// File: rtl/hcm_rmw_pipe.sv
// Hit-count memory: read-modify-write increment pipeline with forwarding and sweep clear.
// Define HCM_SAT_COUNT_EN to saturate the hit-count field instead of wrapping.
module hcm_rmw_pipe #(
   parameter int ROWBITS  = 10,
   parameter int HITNBITS = 3,
   parameter int ADDRBITS = 8,
   parameter int RDLAT    = 2
) (
   input  logic clk,
   input  logic reset,
   hcm_rmw_if.slave bus
);
   localparam int W     = ADDRBITS + HITNBITS;
   localparam int DEPTH = 1 << ROWBITS;

   typedef enum logic [1:0] {RUN, DRAIN, SWEEP} state_t;

   typedef struct packed {
      logic               is_wr;
      logic               nw;
      logic [ROWBITS-1:0] row;
   } req_t;

   typedef struct packed {
      logic               v;
      logic [ROWBITS-1:0] row;
      logic [W-1:0]       word;
   } wb_t;

   state_t              r_state;
   logic [ROWBITS-1:0]  r_sweep;
   logic                r_run, r_busy;
   logic [RDLAT:1]      r_vld_pipe;
   req_t                r_st [1:RDLAT];
   logic [W-1:0]        r_rd [1:RDLAT];
   wb_t                 r_wh [1:RDLAT+1];
   logic [W-1:0]        r_mem [DEPTH];
   logic [ADDRBITS:0]   r_next;
   logic                r_ovf;
   logic                r_oval;
   logic [ROWBITS-1:0]  r_orow;
   logic [W-1:0]        r_odata;

   logic                w_wr_acc, w_rd_acc, w_do_wr, w_do_rd, w_fwd, w_alloc, w_full, w_empty;
   logic [ROWBITS-1:0]  w_acc_row;
   logic [W-1:0]        w_base, w_word;
   logic [HITNBITS-1:0] w_cnt, w_inc;

   // The write side owns the single read port, so a lookup only slips in on idle write cycles.
   assign w_wr_acc  = r_run & bus.wr_valid;
   assign w_rd_acc  = r_run & bus.rd_valid & ~bus.wr_valid;
   assign w_acc_row = bus.wr_valid ? bus.wr_row : bus.rd_row;
   assign w_do_wr   = r_vld_pipe[RDLAT] & r_st[RDLAT].is_wr;
   assign w_do_rd   = r_vld_pipe[RDLAT] & ~r_st[RDLAT].is_wr;
   assign w_full    = r_next[ADDRBITS];
   assign w_empty   = ~(|r_vld_pipe) & ~r_wh[1].v;
   assign w_cnt     = w_base[HITNBITS-1:0];

`ifdef HCM_SAT_COUNT_EN
   assign w_inc = (w_cnt == '1) ? w_cnt : w_cnt + 1'b1;
`else
   assign w_inc = w_cnt + 1'b1;
`endif

   // r_wh[k] holds the hit accepted k cycles before the one now computing; the newest
   // row match wins. Entries 2..RDLAT+1 are already in RAM but landed after our read.
   always_comb begin
      w_fwd  = 1'b0;
      w_base = r_rd[RDLAT];
      for (int k = RDLAT + 1; k >= 1; k--) begin
         if (r_wh[k].v && r_wh[k].row == r_st[RDLAT].row) begin
            w_fwd  = 1'b1;
            w_base = r_wh[k].word;
         end
      end
      w_alloc = r_st[RDLAT].nw & ~w_fwd;
      w_word  = {w_base[W-1:HITNBITS], w_inc};
      if (w_alloc)
         w_word = {(w_full ? {ADDRBITS{1'b1}} : r_next[ADDRBITS-1:0]), HITNBITS'(1)};
   end

   always_ff @(posedge clk) begin
      if (r_state == SWEEP)
         r_mem[r_sweep] <= '0;
      else if (r_wh[1].v)
         r_mem[r_wh[1].row] <= r_wh[1].word;
      r_rd[1] <= r_mem[w_acc_row];
      for (int k = 2; k <= RDLAT; k++) r_rd[k] <= r_rd[k-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= SWEEP;
         r_sweep    <= '0;
         r_run      <= 1'b0;
         r_busy     <= 1'b1;
         r_vld_pipe <= '0;
         for (int k = 1; k <= RDLAT; k++) r_st[k] <= '0;
         for (int k = 1; k <= RDLAT + 1; k++) r_wh[k] <= '0;
         r_next     <= '0;
         r_ovf      <= 1'b0;
         r_oval     <= 1'b0;
         r_orow     <= '0;
         r_odata    <= '0;
      end else begin
         r_vld_pipe[1] <= w_wr_acc | w_rd_acc;
         r_st[1]       <= '{is_wr: bus.wr_valid, nw: bus.wr_new, row: w_acc_row};
         for (int k = 2; k <= RDLAT; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            r_st[k]       <= r_st[k-1];
         end
         r_wh[1] <= '{v: w_do_wr, row: r_st[RDLAT].row, word: w_word};
         for (int k = 2; k <= RDLAT + 1; k++) r_wh[k] <= r_wh[k-1];

         r_oval <= w_do_rd;
         if (w_do_rd) begin
            r_orow  <= r_st[RDLAT].row;
            r_odata <= w_base;
         end

         // Once the address space is exhausted next_addr parks at 2**ADDRBITS.
         if (w_do_wr && w_alloc) begin
            if (w_full) r_ovf  <= 1'b1;
            else        r_next <= r_next + 1'b1;
         end

         case (r_state)
            RUN: if (bus.clear_start) begin
               r_state <= DRAIN;
               r_run   <= 1'b0;
               r_busy  <= 1'b1;
            end
            DRAIN: if (w_empty) begin
               r_state <= SWEEP;
               r_sweep <= '0;
            end
            SWEEP: begin
               r_next  <= '0;
               r_ovf   <= 1'b0;
               for (int k = 1; k <= RDLAT + 1; k++) r_wh[k].v <= 1'b0;
               r_sweep <= r_sweep + 1'b1;
               if (r_sweep == ROWBITS'(DEPTH - 1)) begin
                  r_state <= RUN;
                  r_run   <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= SWEEP;
         endcase
      end
   end

   assign bus.wr_ready       = r_run;
   assign bus.rd_ready       = r_run & ~bus.wr_valid;
   assign bus.out_valid      = r_oval;
   assign bus.out_row        = r_orow;
   assign bus.out_data       = r_odata;
   assign bus.out_nhits      = r_odata[HITNBITS-1:0];
   assign bus.busy           = r_busy;
   assign bus.alloc_overflow = r_ovf;
endmodule

// File: tb/tb_hcm_rmw_pipe.sv
// Scoreboard bench for hcm_rmw_pipe; a 3-bit address field lets allocation run out quickly.
module tb_hcm_rmw_pipe;
   localparam int ROWBITS  = 4;
   localparam int HITNBITS = 3;
   localparam int ADDRBITS = 3;
   localparam int RDLAT    = 2;
   localparam int W        = ADDRBITS + HITNBITS;
   localparam int DEPTH    = 1 << ROWBITS;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hcm_rmw_if #(.ROWBITS(ROWBITS), .HITNBITS(HITNBITS), .ADDRBITS(ADDRBITS)) bus ();

   hcm_rmw_pipe #(.ROWBITS(ROWBITS), .HITNBITS(HITNBITS), .ADDRBITS(ADDRBITS), .RDLAT(RDLAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int           row;
      logic [W-1:0] data;
   } exp_t;

   exp_t         q[$];
   logic [W-1:0] m_mem [DEPTH];
   int           m_next;
   bit           m_ovf;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_next = 0;
      m_ovf  = 1'b0;
   endfunction

   function automatic void m_hit(input int row, input bit nw);
      logic [ADDRBITS-1:0] a;
      logic [HITNBITS-1:0] c;
      if (nw) begin
         if (m_next == (1 << ADDRBITS)) begin
            a     = '1;
            m_ovf = 1'b1;
         end else begin
            a = ADDRBITS'(m_next);
            m_next++;
         end
         m_mem[row] = {a, HITNBITS'(1)};
      end else begin
         c = m_mem[row][HITNBITS-1:0];
`ifdef HCM_SAT_COUNT_EN
         if (c != '1) c = c + 1'b1;
`else
         c = c + 1'b1;
`endif
         m_mem[row][HITNBITS-1:0] = c;
      end
   endfunction

   always @(negedge clk) begin
      if (!reset && bus.out_valid) begin
         if (q.size() == 0) check("unexpected_out_valid", 1, 0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("out_row",   bus.out_row,   e.row);
            check("out_data",  bus.out_data,  e.data);
            check("out_nhits", bus.out_nhits, e.data[HITNBITS-1:0]);
         end
      end
   end

   task automatic wait_run();
      int n = 0;
      while (!bus.wr_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.wr_ready) check("wr_ready_timeout", 0, 1);
   endtask

   task automatic hit(input int row, input bit nw);
      wait_run();
      bus.wr_valid = 1'b1;
      bus.wr_row   = ROWBITS'(row);
      bus.wr_new   = nw;
      @(posedge clk);
      m_hit(row, nw);
      #1;
      bus.wr_valid = 1'b0;
      bus.wr_new   = 1'b0;
   endtask

   task automatic lookup(input int row);
      wait_run();
      bus.rd_valid = 1'b1;
      bus.rd_row   = ROWBITS'(row);
      @(posedge clk);
      q.push_back('{row: row, data: m_mem[row]});
      #1;
      bus.rd_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n;
      int rows[4];
      rows = '{3, 7, 9, 2};
      reset = 1'b1;
      bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_new = 1'b0;
      bus.rd_valid = 1'b0; bus.rd_row = '0; bus.clear_start = 1'b0;
      m_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",      bus.busy, 1);
      check("rst_wr_ready",  bus.wr_ready, 0);
      check("rst_rd_ready",  bus.rd_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data, 0);
      check("rst_ovf",       bus.alloc_overflow, 0);
      reset = 1'b0;

      n = 0;
      while (bus.busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("sweep_cycles", n, DEPTH);
      check("ready_after_sweep", bus.wr_ready, 1);

      // first lookup: latency RDLAT+1 from the accept cycle
      bus.rd_valid = 1'b1;
      bus.rd_row   = 4'd5;
      @(posedge clk);
      q.push_back('{row: 5, data: m_mem[5]});
      #1;
      bus.rd_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rd_latency", lat, RDLAT);

      hit(3, 1); hit(7, 1); lookup(3); lookup(7);

      hit(9, 1);
      repeat (4) hit(9, 0);
      lookup(9);

      // write and lookup together: only the write goes in
      bus.wr_valid = 1'b1; bus.wr_row = 4'd9; bus.wr_new = 1'b0;
      bus.rd_valid = 1'b1; bus.rd_row = 4'd9;
      #1;
      check("rd_ready_blocked", bus.rd_ready, 0);
      @(posedge clk);
      m_hit(9, 0);
      #1;
      bus.wr_valid = 1'b0;
      #1;
      check("rd_ready_retry", bus.rd_ready, 1);
      @(posedge clk);
      q.push_back('{row: 9, data: m_mem[9]});
      #1;
      bus.rd_valid = 1'b0;

      hit(2, 1);
      repeat (8) hit(2, 0);
      lookup(2);

      repeat (40) begin
         int r;
         r = rows[$urandom_range(0, 3)];
         if ($urandom_range(0, 1) == 1) hit(r, 0);
         else lookup(r);
      end
      repeat (8) @(posedge clk);
      #1;

      bus.clear_start = 1'b1;
      @(posedge clk);
      m_clear();
      #1;
      bus.clear_start = 1'b0;
      check("clear_busy", bus.busy, 1);
      check("clear_wr_ready", bus.wr_ready, 0);
      wait_run();

      for (int i = 0; i < 9; i++) hit(i, 1);
      repeat (6) @(posedge clk);
      #1;
      check("alloc_overflow_set", bus.alloc_overflow, 1);
      for (int i = 0; i < 9; i++) lookup(i);

      // clear issued together with an accepted hit
      wait_run();
      bus.wr_valid = 1'b1; bus.wr_row = 4'd4; bus.wr_new = 1'b0;
      bus.clear_start = 1'b1;
      @(posedge clk);
      m_hit(4, 0);
      m_clear();
      #1;
      bus.wr_valid = 1'b0;
      bus.clear_start = 1'b0;
      check("clear2_busy", bus.busy, 1);
      wait_run();
      check("alloc_overflow_cleared", bus.alloc_overflow, 0);
      for (int i = 0; i < DEPTH; i++) lookup(i);
      repeat (6) @(posedge clk);
      #1;

      // reset with work in flight: nothing may come out
      hit(5, 1);
      lookup(5);
      reset = 1'b1;
      q.delete();
      m_clear();
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_busy", bus.busy, 1);
      wait_run();
      lookup(5);
      hit(6, 1);
      lookup(6);

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
